// File: rtl/sam_pkg.sv
// Shared opcodes, instruction field positions and FSM state type for the
// sam_stream_engine command engine.
package sam_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int OP_MSB   = 31;
  localparam int ADDR_LSB = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/sam_ram_sp.sv
// Single-port RAM: synchronous write, registered read (read-before-write on
// the shared address).
module sam_ram_sp #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto a RAM macro; its contents
  // survive rstn and only change through writes (including CLEAR).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sam_stream_engine.sv
// Stream command engine: WRITE / READ-burst / CLEAR instructions against a
// single-port RAM, read data returned through a 2-entry output buffer.
// Optional write acknowledges are enabled by defining SAM_WR_ACK_EN.
module sam_stream_engine
  import sam_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  state_t state, next_state;

  logic [ADDR_W-1:0] rd_ptr, end_ptr, clr_ptr;

  logic [1:0]        op;
  logic [ADDR_W-1:0] a_fld, e_fld;
  logic [DATA_W-1:0] d_fld;

  logic              accept, pop, room, issue;
  logic [2:0]        level;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic              pipe_valid, pipe_last;
  logic [OUT_W-1:0]  push_data;

  logic [OUT_W-1:0]  buf_data [2];
  logic [1:0]        buf_last;
  logic              wr_idx, rd_idx;
  logic [1:0]        count;

  logic              unused;

  assign op     = in_data[OP_MSB -: 2];
  assign a_fld  = in_data[ADDR_LSB +: ADDR_W];
  assign e_fld  = in_data[ADDR_W-1:0];
  assign d_fld  = in_data[DATA_W-1:0];
  assign unused = ^{in_last, in_data};

  assign pop   = out_valid && out_ready;
  // Words already buffered plus the one in the RAM read pipeline must leave
  // a free slot, counting a slot freed by this cycle's pop.
  assign level = {1'b0, count} + {2'b00, pipe_valid} - {2'b00, pop};
  assign room  = level < 3'd2;

`ifdef SAM_WR_ACK_EN
  logic             pipe_ack;
  logic [OUT_W-1:0] pipe_ack_word;
  logic             ack_go;

  assign in_ready = (state == IDLE) && rstn && ((op != OP_WRITE) || room);
  assign ack_go   = accept && (op == OP_WRITE);
`else
  assign in_ready = (state == IDLE) && rstn;
`endif

  assign accept = in_valid && in_ready;

  sam_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every signal written here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ram_we     = 1'b0;
    ram_addr   = rd_ptr;
    ram_wdata  = '0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_WRITE: begin
              ram_we    = 1'b1;
              ram_addr  = a_fld;
              ram_wdata = d_fld;
            end
            OP_READ:  next_state = READ;
            OP_CLEAR: next_state = CLEAR;
            OP_NOP:   ;
            default:  ;
          endcase
        end
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (rd_ptr == end_ptr) next_state = IDLE;
        end
      end
      CLEAR: begin
        // Gated so a reset landing mid-clear leaves the remaining words intact.
        ram_we   = rstn;
        ram_addr = clr_ptr;
        if (clr_ptr == '1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      end_ptr <= '0;
      clr_ptr <= '0;
    end else begin
      if (accept && (op == OP_READ)) begin
        rd_ptr  <= a_fld;
        end_ptr <= e_fld;
      end else if (issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (accept && (op == OP_CLEAR)) begin
        clr_ptr <= '0;
      end else if (state == CLEAR) begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
      end
    end
  end

  // One-deep pipeline tracking the word that lands in the buffer next cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_valid <= 1'b0;
      pipe_last  <= 1'b0;
`ifdef SAM_WR_ACK_EN
      pipe_ack      <= 1'b0;
      pipe_ack_word <= '0;
`endif
    end else begin
`ifdef SAM_WR_ACK_EN
      pipe_valid    <= issue || ack_go;
      pipe_last     <= issue ? (rd_ptr == end_ptr) : ack_go;
      pipe_ack      <= ack_go;
      pipe_ack_word <= OUT_W'({OP_WRITE, a_fld, 16'(d_fld)});
`else
      pipe_valid <= issue;
      pipe_last  <= issue && (rd_ptr == end_ptr);
`endif
    end
  end

`ifdef SAM_WR_ACK_EN
  assign push_data = pipe_ack ? pipe_ack_word : OUT_W'(ram_rdata);
`else
  assign push_data = OUT_W'(ram_rdata);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (pipe_valid) begin
        buf_data[wr_idx] <= push_data;
        buf_last[wr_idx] <= pipe_last;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      count <= count + {1'b0, pipe_valid} - {1'b0, pop};
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[rd_idx];
  assign out_last  = out_valid && buf_last[rd_idx];
  assign busy      = (state != IDLE) || out_valid || pipe_valid;

endmodule

// File: tb/tb_sam_stream_engine.sv
// Self-checking bench for sam_stream_engine: a word-level memory model and an
// expected-output queue, with randomized data and output backpressure.
module tb_sam_stream_engine;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int MASK   = DEPTH - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;

  sam_stream_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          tests  = 0;
  int          failed = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic [DATA_W-1:0] mem_m [DEPTH];
  beat_t             exp_q [$];
  int unsigned       rx_cyc [$];
  int                rdy_mode   = 0;
  int                stall_left = 0;
  int                rx_count   = 0;

  // Output monitor: sets out_ready for the coming edge, then scores transfers
  // and checks that a stalled word holds still.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  beat_t       mon_e;
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          if (rx_count == 3 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = cyc[0];
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
            failed++;
            $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                     out_valid, out_data, out_last, prev_data, prev_last);
          end
        end
        if (out_valid === 1'b1 && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_word: got data=%h last=%0b, want no word", out_data, out_last);
          end else begin
            mon_e = exp_q.pop_front();
            if (out_data !== mon_e.data || out_last !== mon_e.last) begin
              failed++;
              $display("FAIL out_word: got data=%h last=%0b, want data=%h last=%0b",
                       out_data, out_last, mon_e.data, mon_e.last);
            end
          end
          rx_count++;
          rx_cyc.push_back(cyc);
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [1:0] op, input int a, input int low);
    return {op, a[13:0], low[15:0]};
  endfunction

  task automatic send(input logic [31:0] w, output int unsigned acc);
    int n;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    in_last  = 1'($urandom_range(0, 1));
    n = 0;
    #1;
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: got in_ready=%0b after %0d cycles, want 1", in_ready, n);
      in_valid = 1'b0;
      acc = 0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic do_write(input int a, input int d, output int unsigned acc);
    mem_m[a & MASK] = d[DATA_W-1:0];
    send(enc(2'b01, a, d), acc);
  endtask

  task automatic model_read(input int a, input int e);
    int    len;
    beat_t b;
    len = (((e - a) % DEPTH) + DEPTH) % DEPTH + 1;
    for (int i = 0; i < len; i++) begin
      b.data = {16'h0000, mem_m[(a + i) & MASK]};
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic do_read(input int a, input int e, output int unsigned acc);
    model_read(a & MASK, e & MASK);
    send(enc(2'b10, a, e), acc);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      #2;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drain: got %0d words outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    #2;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL %s_idle: got out_valid=%0b busy=%0b, want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      failed++;
      $display("FAIL reset_in_ready: got %0b, want 0", in_ready);
    end
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got valid=%0b last=%0b data=%h busy=%0b, want 0 0 0 0",
               out_valid, out_last, out_data, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_release_ready: got %0b, want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int unsigned acc, lat;
    rdy_mode = 0;
    do_write(5, 'hBEEF, acc);
    send(enc(2'b00, 5, 'h1234), acc);
    model_read(5, 5);
    send(enc(2'b10, 5, 5), acc);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1) break;
    end
    lat = cyc - acc;
    tests++;
    if (out_valid !== 1'b1 || lat != 2) begin
      failed++;
      $display("FAIL single_latency: got valid=%0b after %0d cycles, want valid=1 after 2",
               out_valid, lat);
    end
    wait_drain("single");
  endtask

  task automatic test_burst8();
    int unsigned accs [8];
    int unsigned acc;
    int          bad;
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) do_write(i, 'h10 + i, accs[i]);
    bad = 0;
    for (int i = 1; i < 8; i++) if (accs[i] - accs[i-1] != 1) bad++;
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL write_rate: got %0d non-consecutive accepts, want 0", bad);
    end
    rx_cyc.delete();
    do_read(0, 7, acc);
    wait_drain("burst8");
    bad = 0;
    for (int i = 1; i < rx_cyc.size(); i++) if (rx_cyc[i] - rx_cyc[i-1] != 1) bad++;
    tests++;
    if (rx_cyc.size() != 8 || bad != 0) begin
      failed++;
      $display("FAIL burst8_rate: got %0d words with %0d gaps, want 8 words with 0 gaps",
               rx_cyc.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    int unsigned acc;
    rx_count   = 0;
    stall_left = 3;
    rdy_mode   = 1;
    do_read(0, 7, acc);
    wait_drain("backpressure");
    rdy_mode = 0;
  endtask

  task automatic test_wrap();
    int unsigned acc;
    do_write('h3FFE, 'hA, acc);
    do_write('h3FFF, 'hB, acc);
    do_write('h0000, 'hC, acc);
    do_read('h3FFE, 'h0000, acc);
    wait_drain("wrap");
  endtask

  task automatic test_back_to_back();
    int unsigned acc;
    rdy_mode = 2;
    do_read(0, 3, acc);
    do_read('h3FFE, 'h3FFF, acc);
    do_write(2, $urandom_range(0, 'hFFFF), acc);
    do_read(1, 2, acc);
    wait_drain("back_to_back");
    rdy_mode = 0;
  endtask

  task automatic test_random();
    int unsigned acc;
    int          s, len;
    rdy_mode = 2;
    for (int off = 0; off < 32; off++)
      do_write(('h3FF0 + off) & MASK, $urandom_range(0, 'hFFFF), acc);
    repeat (30) begin
      if ($urandom_range(0, 3) == 0) begin
        do_write(('h3FF0 + $urandom_range(0, 31)) & MASK, $urandom_range(0, 'hFFFF), acc);
      end else begin
        s   = $urandom_range(0, 31);
        len = $urandom_range(1, 32 - s);
        do_read(('h3FF0 + s) & MASK, ('h3FF0 + s + len - 1) & MASK, acc);
      end
    end
    wait_drain("random");
    rdy_mode = 0;
  endtask

  task automatic test_reset_midburst();
    int unsigned acc;
    rdy_mode = 0;
    for (int i = 0; i < 100; i++) do_write(i, $urandom_range(0, 'hFFFF), acc);
    do_read(0, 99, acc);
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failed++;
      $display("FAIL midreset_state: got valid=%0b busy=%0b in_ready=%0b, want 0 0 0",
               out_valid, busy, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL midreset_release: got in_ready=%0b busy=%0b, want 1 0", in_ready, busy);
    end
    do_read(0, 99, acc);
    wait_drain("midreset_reread");
  endtask

  task automatic test_clear();
    int unsigned acc;
    int          bad;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    send(enc(2'b11, 0, 0), acc);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      #2;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      failed++;
      $display("FAIL clear_busy: got %0d cycles not busy, want 0 of %0d", bad, DEPTH);
    end
    @(negedge clk);
    #2;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++;
      $display("FAIL clear_done: got busy=%0b in_ready=%0b, want 0 1", busy, in_ready);
    end
    do_read('h3FFE, 'h0001, acc);
    wait_drain("clear_read");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst8();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_midburst();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
